// File: rtl/snake_pkg.sv
// Shared types for the snake tile engine: FSM states, directions,
// grid cells, default colours and the opposite-direction helper.
package snake_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_WAIT,
    S_MOVE,
    S_HEAD,
    S_TAIL,
    S_APPLE,
    S_DEAD
  } state_t;

  typedef enum logic [1:0] {
    DIR_R = 2'd0,
    DIR_D = 2'd1,
    DIR_U = 2'd2,
    DIR_L = 2'd3
  } dir_t;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } cell_t;

  localparam logic [2:0] COL_SNAKE = 3'b010;
  localparam logic [2:0] COL_APPLE = 3'b100;
  localparam logic [2:0] COL_BG    = 3'b000;

  // R/L and D/U are bitwise complements in this encoding.
  function automatic dir_t OPP(input dir_t d);
    return dir_t'(~d);
  endfunction

endpackage

// File: rtl/cell_scanner.sv
// Scans one CELL x CELL tile row-major, one pixel per cycle.
// start_i/col_i/row_i/colour_i in; vga_x_o/vga_y_o/vga_colour_o/plot_o/done_o out.
module cell_scanner
  import snake_pkg::*;
#(
  parameter int CELL = 10
) (
  input  logic       CLOCK_50,
  input  logic       Resetn,
  input  logic       start_i,
  input  logic [3:0] col_i,
  input  logic [3:0] row_i,
  input  logic [2:0] colour_i,
  output logic [7:0] vga_x_o,
  output logic [6:0] vga_y_o,
  output logic [2:0] vga_colour_o,
  output logic       plot_o,
  output logic       done_o
);

  localparam int CW = $clog2(CELL) + 1;
  localparam logic [CW-1:0] LAST = CW'(CELL - 1);

  logic [CW-1:0] px_q;
  logic [CW-1:0] py_q;
  cell_t         at_q;
  logic [2:0]    colour_q;
  logic          busy_q;
  logic          last;

  assign last = busy_q && (px_q == LAST) && (py_q == LAST);

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      px_q     <= '0;
      py_q     <= '0;
      at_q     <= '0;
      colour_q <= '0;
      busy_q   <= 1'b0;
    end else if (busy_q) begin
      if (last) begin
        busy_q <= 1'b0;
        px_q   <= '0;
        py_q   <= '0;
      end else if (px_q == LAST) begin
        px_q <= '0;
        py_q <= py_q + 1'b1;
      end else begin
        px_q <= px_q + 1'b1;
      end
    end else if (start_i) begin
      busy_q   <= 1'b1;
      px_q     <= '0;
      py_q     <= '0;
      at_q     <= '{x: col_i, y: row_i};
      colour_q <= colour_i;
    end
  end

  // Full-width address, then truncated to the adapter's bus.
  assign vga_x_o = 8'(32'(at_q.x) * 32'(CELL) + 32'(px_q));
  assign vga_y_o = 7'(32'(at_q.y) * 32'(CELL) + 32'(py_q));
  assign vga_colour_o = colour_q;
  assign plot_o       = busy_q;
  assign done_o       = last;

endmodule

// File: rtl/snake_tile_engine.sv
// Grid snake engine: FSM, segment buffer, direction latch, collisions, tick.
// Ports: CLOCK_50/Resetn/start/dir_req/apple in; vga_*/plot/eaten/game_over/length out.
module snake_tile_engine
  import snake_pkg::*;
#(
  parameter int          CELL    = 10,
  parameter int          GRID_W  = 16,
  parameter int          GRID_H  = 12,
  parameter int          MAX_LEN = 16,
  parameter int          K       = 20,
  parameter logic [2:0]  C_SNAKE = COL_SNAKE,
  parameter logic [2:0]  C_APPLE = COL_APPLE,
  parameter logic [2:0]  C_BG    = COL_BG
) (
  input  logic                           CLOCK_50,
  input  logic                           Resetn,
  input  logic                           start,
  input  logic [3:0]                     dir_req,
  input  logic [3:0]                     apple_x,
  input  logic [3:0]                     apple_y,
  output logic [7:0]                     vga_x,
  output logic [6:0]                     vga_y,
  output logic [2:0]                     vga_colour,
  output logic                           plot,
  output logic                           eaten,
  output logic                           game_over,
  output logic [$clog2(MAX_LEN+1)-1:0]   length
);

  localparam int LW = $clog2(MAX_LEN + 1);

  state_t        state_q;
  dir_t          dir_q;
  dir_t          nd_q;
  cell_t         seg_q [MAX_LEN];
  logic [LW-1:0] len_q;
  cell_t         tail_q;
  logic          vac_q;
  logic          eaten_q;
  logic          over_q;
  logic          started_q;
  logic [K-1:0]  tick_q;

  logic          tick;
  logic          req_v;
  dir_t          req_d;
  cell_t         head_c;
  cell_t         nxt_c;
  cell_t         tail_c;
  logic          wall_c;
  logic          hit_c;
  logic          grow_c;
  logic          self_c;
  logic          scan_st;
  logic          scan_go;
  logic          scan_done;
  cell_t         sc_cell;
  logic [2:0]    sc_col;

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) tick_q <= '0;
    else         tick_q <= tick_q + 1'b1;
  end

  assign tick = (tick_q == '0);

  // Several keys at once: right > down > up > left.
  always_comb begin
    req_v = 1'b1;
    req_d = DIR_R;
    priority case (1'b1)
      dir_req[0]: req_d = DIR_R;
      dir_req[1]: req_d = DIR_D;
      dir_req[2]: req_d = DIR_U;
      dir_req[3]: req_d = DIR_L;
      default:    req_v = 1'b0;
    endcase
  end

  always_comb begin
    head_c = seg_q[0];
    nxt_c  = seg_q[0];
    wall_c = 1'b0;
    unique case (nd_q)
      DIR_R: begin
        wall_c  = head_c.x == 4'(GRID_W - 1);
        nxt_c.x = head_c.x + 4'd1;
      end
      DIR_D: begin
        wall_c  = head_c.y == 4'(GRID_H - 1);
        nxt_c.y = head_c.y + 4'd1;
      end
      DIR_U: begin
        wall_c  = head_c.y == 4'd0;
        nxt_c.y = head_c.y - 4'd1;
      end
      DIR_L: begin
        wall_c  = head_c.x == 4'd0;
        nxt_c.x = head_c.x - 4'd1;
      end
    endcase
    hit_c  = (nxt_c.x == apple_x) && (nxt_c.y == apple_y);
    grow_c = hit_c && (len_q < LW'(MAX_LEN));
    tail_c = seg_q[0];
    self_c = 1'b0;
    // The tail cell is free to enter unless the snake grows this move.
    for (int i = 0; i < MAX_LEN; i++) begin
      if (LW'(i) == len_q - 1'b1) tail_c = seg_q[i];
      if ((LW'(i) < len_q) && (seg_q[i] == nxt_c) &&
          !((LW'(i) == len_q - 1'b1) && !grow_c))
        self_c = 1'b1;
    end
  end

  assign scan_st = (state_q == S_HEAD) || (state_q == S_TAIL) ||
                   (state_q == S_APPLE);
  // First cycle of each scan state only launches the scanner,
  // which leaves one idle cycle between consecutive scans.
  assign scan_go = scan_st && !started_q;

  always_comb begin
    sc_cell = seg_q[0];
    sc_col  = C_SNAKE;
    if (state_q == S_TAIL) begin
      sc_cell = tail_q;
      sc_col  = C_BG;
    end else if (state_q == S_APPLE) begin
      sc_cell = '{x: apple_x, y: apple_y};
      sc_col  = C_APPLE;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      state_q   <= S_IDLE;
      dir_q     <= DIR_R;
      nd_q      <= DIR_R;
      len_q     <= '0;
      tail_q    <= '0;
      vac_q     <= 1'b0;
      eaten_q   <= 1'b0;
      over_q    <= 1'b0;
      started_q <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) seg_q[i] <= '0;
    end else begin
      eaten_q <= 1'b0;
      if (req_v && (req_d != OPP(dir_q))) nd_q <= req_d;
      unique case (state_q)
        S_IDLE: begin
          if (start) state_q <= S_INIT;
        end
        S_INIT: begin
          for (int i = 1; i < MAX_LEN; i++) seg_q[i] <= '0;
          seg_q[0] <= '{x: 4'(GRID_W / 2), y: 4'(GRID_H / 2)};
          len_q    <= LW'(1);
          dir_q    <= DIR_R;
          nd_q     <= DIR_R;
          vac_q    <= 1'b0;
          state_q  <= S_HEAD;
        end
        S_WAIT: begin
          if (tick) state_q <= S_MOVE;
        end
        S_MOVE: begin
          if (wall_c || self_c) begin
            over_q  <= 1'b1;
            state_q <= S_DEAD;
          end else begin
            tail_q <= tail_c;
            vac_q  <= !grow_c;
            for (int i = 1; i < MAX_LEN; i++) seg_q[i] <= seg_q[i-1];
            seg_q[0] <= nxt_c;
            len_q    <= len_q + LW'(grow_c);
            eaten_q  <= hit_c;
            dir_q    <= nd_q;
            state_q  <= S_HEAD;
          end
        end
        S_HEAD, S_TAIL, S_APPLE: begin
          if (scan_go) started_q <= 1'b1;
          if (scan_done) begin
            started_q <= 1'b0;
            if (state_q == S_HEAD)
              state_q <= vac_q ? S_TAIL : S_APPLE;
            else if (state_q == S_TAIL)
              state_q <= S_APPLE;
            else
              state_q <= S_WAIT;
          end
        end
        S_DEAD: begin
          if (start) begin
            over_q  <= 1'b0;
            state_q <= S_INIT;
          end
        end
      endcase
    end
  end

  cell_scanner #(
    .CELL(CELL)
  ) u_scan (
    .CLOCK_50    (CLOCK_50),
    .Resetn      (Resetn),
    .start_i     (scan_go),
    .col_i       (sc_cell.x),
    .row_i       (sc_cell.y),
    .colour_i    (sc_col),
    .vga_x_o     (vga_x),
    .vga_y_o     (vga_y),
    .vga_colour_o(vga_colour),
    .plot_o      (plot),
    .done_o      (scan_done)
  );

  assign eaten     = eaten_q;
  assign game_over = over_q;
  assign length    = len_q;

endmodule
